// File: rtl/calc_sequencer.sv
// Operation sequencer for a 40-bit ALU and square-root unit: latches operands,
// pulses the selected unit's start, waits for its done and registers the result.
// Optional WAIT watchdog enabled by defining CALC_SEQ_TIMEOUT_EN (limit = TIMEOUT).
module calc_sequencer #(
  parameter int TIMEOUT = 1023
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CLR,
  input  logic        REQ,
  input  logic [2:0]  OP,
  input  logic [39:0] A,
  input  logic [39:0] B,
  output logic [39:0] OPA,
  output logic [39:0] OPB,
  output logic        ALU_START,
  output logic [1:0]  ALU_OP,
  input  logic        ALU_DONE,
  input  logic        ALU_COUT,
  input  logic [39:0] ALU_S,
  input  logic [39:0] ALU_Q,
  output logic        RZ_START,
  input  logic        RZ_DONE,
  input  logic        RZ_COUT,
  input  logic [39:0] RZ_OUT,
  output logic [39:0] RESULT,
  output logic        OVF,
  output logic        ERR,
  output logic        BUSY,
  output logic        VALID
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE, S_FAIL
  } state_t;

  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_SQRT = 3'b100;

  state_t      state;
  logic [2:0]  op_q;
  logic        unit_done;
  logic        unit_cout;
  logic [39:0] unit_result;

`ifdef CALC_SEQ_TIMEOUT_EN
  localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);
  logic [9:0] wd_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign ALU_OP = op_q[1:0];

  // Only the unit that was started is observed; the other unit's handshake is ignored.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    unit_done   = ALU_DONE;
    unit_cout   = ALU_COUT;
    unit_result = ALU_S;
    if (op_q == OP_SQRT) begin
      unit_done   = RZ_DONE;
      unit_cout   = RZ_COUT;
      unit_result = RZ_OUT;
    end else if (op_q[1]) begin
      unit_result = ALU_Q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      // A user clear returns everything to the same values as reset.
      state     <= S_IDLE;
      op_q      <= '0;
      OPA       <= '0;
      OPB       <= '0;
      ALU_START <= 1'b0;
      RZ_START  <= 1'b0;
      RESULT    <= '0;
      OVF       <= 1'b0;
      ERR       <= 1'b0;
      BUSY      <= 1'b0;
      VALID     <= 1'b0;
`ifdef CALC_SEQ_TIMEOUT_EN
      wd_cnt    <= '0;
`endif
    end else begin
      ALU_START <= 1'b0;
      RZ_START  <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (REQ) begin
            state <= S_LOAD;
            OPA   <= A;
            OPB   <= B;
            op_q  <= OP;
            VALID <= 1'b0;
            ERR   <= 1'b0;
            OVF   <= 1'b0;
            BUSY  <= 1'b1;
          end
        end
        S_LOAD: begin
          // Illegal opcodes and divide-by-zero fail without starting any unit.
          if (op_q > OP_SQRT || (op_q == OP_DIV && OPB == '0)) begin
            state  <= S_FAIL;
            ERR    <= 1'b1;
            RESULT <= '0;
            BUSY   <= 1'b0;
          end else begin
            state     <= S_START;
            ALU_START <= (op_q != OP_SQRT);
            RZ_START  <= (op_q == OP_SQRT);
          end
        end
        S_START: begin
          state  <= S_WAIT;
`ifdef CALC_SEQ_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (unit_done) begin
            state  <= S_DONE;
            RESULT <= unit_result;
            OVF    <= unit_cout;
            VALID  <= 1'b1;
            BUSY   <= 1'b0;
          end
`ifdef CALC_SEQ_TIMEOUT_EN
          // A done arriving in the expiry cycle takes priority over the timeout.
          else if (wd_cnt == WD_LAST) begin
            state  <= S_FAIL;
            ERR    <= 1'b1;
            RESULT <= '0;
            BUSY   <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 10'd1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer; inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_calc_sequencer;

  logic        CLK = 1'b0;
  logic        RST, CLR, REQ;
  logic [2:0]  OP;
  logic [39:0] A, B;
  logic [39:0] OPA, OPB;
  logic        ALU_START;
  logic [1:0]  ALU_OP;
  logic        ALU_DONE, ALU_COUT;
  logic [39:0] ALU_S, ALU_Q;
  logic        RZ_START;
  logic        RZ_DONE, RZ_COUT;
  logic [39:0] RZ_OUT;
  logic [39:0] RESULT;
  logic        OVF, ERR, BUSY, VALID;

  int checks_total  = 0;
  int checks_passed = 0;
  int alu_starts    = 0;
  int rz_starts     = 0;
  int alu_base, rz_base;

  calc_sequencer #(.TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .REQ(REQ), .OP(OP), .A(A), .B(B),
    .OPA(OPA), .OPB(OPB), .ALU_START(ALU_START), .ALU_OP(ALU_OP),
    .ALU_DONE(ALU_DONE), .ALU_COUT(ALU_COUT), .ALU_S(ALU_S), .ALU_Q(ALU_Q),
    .RZ_START(RZ_START), .RZ_DONE(RZ_DONE), .RZ_COUT(RZ_COUT), .RZ_OUT(RZ_OUT),
    .RESULT(RESULT), .OVF(OVF), .ERR(ERR), .BUSY(BUSY), .VALID(VALID)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (ALU_START === 1'b1) alu_starts++;
    if (RZ_START === 1'b1) rz_starts++;
  end

  task automatic check(input string tag, input logic [39:0] observed, input logic [39:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [39:0] a, input logic [39:0] b);
    OP = op; A = a; B = b; REQ = 1'b1;
    cyc(1);
    REQ = 1'b0;
  endtask

  initial begin
    RST = 1'b1; CLR = 1'b0; REQ = 1'b0; OP = '0; A = '0; B = '0;
    ALU_DONE = 1'b0; ALU_COUT = 1'b0; ALU_S = '0; ALU_Q = '0;
    RZ_DONE = 1'b0; RZ_COUT = 1'b0; RZ_OUT = '0;
    cyc(2);
    RST = 1'b0;

    // Reset state
    check("rst_result", RESULT, 40'h0);
    check("rst_opa", OPA, 40'h0);
    check("rst_flags", {35'h0, ALU_START, RZ_START, OVF, ERR, BUSY}, 40'h0);
    check("rst_valid", VALID, 40'h0);

    // Add: 5 + 3 with ALU_DONE two cycles after ALU_START
    alu_base = alu_starts; rz_base = rz_starts;
    issue(3'b000, 40'h5, 40'h3);
    check("add_load_busy", BUSY, 40'h1);
    check("add_opa", OPA, 40'h5);
    check("add_opb", OPB, 40'h3);
    check("add_no_start_in_load", ALU_START, 40'h0);
    cyc(1);
    check("add_alu_start", ALU_START, 40'h1);
    check("add_rz_start_low", RZ_START, 40'h0);
    check("add_alu_op", ALU_OP, 40'h0);
    cyc(1);
    check("add_start_one_cycle", ALU_START, 40'h0);
    cyc(1);
    ALU_DONE = 1'b1; ALU_S = 40'h8; ALU_Q = 40'hF0;
    cyc(1);
    ALU_DONE = 1'b0;
    check("add_result", RESULT, 40'h8);
    check("add_valid", VALID, 40'h1);
    check("add_err", ERR, 40'h0);
    check("add_busy_low", BUSY, 40'h0);
    check("add_alu_starts", 40'(alu_starts - alu_base), 40'h1);
    check("add_rz_starts", 40'(rz_starts - rz_base), 40'h0);
    cyc(3);
    check("add_hold_result", RESULT, 40'h8);
    check("add_hold_valid", VALID, 40'h1);

    // Divide by zero fails two cycles after REQ without a start pulse
    alu_base = alu_starts; rz_base = rz_starts;
    issue(3'b011, 40'h7, 40'h0);
    check("div0_valid_cleared", VALID, 40'h0);
    cyc(1);
    check("div0_err", ERR, 40'h1);
    check("div0_result", RESULT, 40'h0);
    check("div0_busy", BUSY, 40'h0);
    cyc(2);
    check("div0_err_hold", ERR, 40'h1);
    check("div0_no_starts", 40'((alu_starts - alu_base) + (rz_starts - rz_base)), 40'h0);

    // Invalid opcode
    issue(3'b110, 40'h1, 40'h1);
    check("inv_err_cleared", ERR, 40'h0);
    cyc(1);
    check("inv_err", ERR, 40'h1);
    check("inv_no_starts", 40'((alu_starts - alu_base) + (rz_starts - rz_base)), 40'h0);

    // Square root with a stray ALU_DONE during WAIT
    alu_base = alu_starts; rz_base = rz_starts;
    issue(3'b100, 40'h0, 40'h51);
    cyc(1);
    check("sqrt_rz_start", RZ_START, 40'h1);
    check("sqrt_alu_start_low", ALU_START, 40'h0);
    cyc(1);
    ALU_DONE = 1'b1; ALU_S = 40'h77; ALU_Q = 40'h66; ALU_COUT = 1'b1;
    cyc(1);
    ALU_DONE = 1'b0;
    check("sqrt_ignore_alu_busy", BUSY, 40'h1);
    check("sqrt_ignore_alu_valid", VALID, 40'h0);
    RZ_DONE = 1'b1; RZ_OUT = 40'h9; RZ_COUT = 1'b0;
    cyc(1);
    RZ_DONE = 1'b0;
    check("sqrt_result", RESULT, 40'h9);
    check("sqrt_valid", VALID, 40'h1);
    check("sqrt_ovf_from_rz", OVF, 40'h0);
    check("sqrt_starts", 40'({alu_starts - alu_base, 4'(rz_starts - rz_base)}), 40'h1);

    // Multiply selects ALU_Q and latches carry; stray RZ_DONE ignored
    issue(3'b010, 40'h100, 40'h200);
    cyc(2);
    RZ_DONE = 1'b1; RZ_OUT = 40'hAA;
    cyc(1);
    RZ_DONE = 1'b0;
    check("mul_ignore_rz", BUSY, 40'h1);
    ALU_DONE = 1'b1; ALU_Q = 40'h12_3456_789A; ALU_S = 40'hDEAD; ALU_COUT = 1'b1;
    cyc(1);
    ALU_DONE = 1'b0; ALU_COUT = 1'b0;
    check("mul_result", RESULT, 40'h12_3456_789A);
    check("mul_ovf", OVF, 40'h1);

    // Second REQ while busy is ignored
    alu_base = alu_starts;
    issue(3'b001, 40'h10, 40'h4);
    cyc(1);
    A = 40'h99; REQ = 1'b1;
    cyc(1);
    check("busy_req_opa", OPA, 40'h10);
    cyc(1);
    REQ = 1'b0;
    check("busy_req_opa_wait", OPA, 40'h10);
    check("busy_req_alu_op", ALU_OP, 40'h1);
    check("busy_req_busy", BUSY, 40'h1);
    ALU_DONE = 1'b1; ALU_S = 40'hC;
    cyc(1);
    ALU_DONE = 1'b0;
    check("sub_result", RESULT, 40'hC);
    check("busy_req_one_start", 40'(alu_starts - alu_base), 40'h1);
    ALU_DONE = 1'b1; ALU_S = 40'h55;
    cyc(1);
    ALU_DONE = 1'b0;
    check("spurious_done_result", RESULT, 40'hC);
    check("spurious_done_valid", VALID, 40'h1);

    // RST one cycle before ALU_DONE abandons the operation
    issue(3'b000, 40'h2, 40'h2);
    cyc(3);
    RST = 1'b1;
    cyc(1);
    RST = 1'b0;
    ALU_DONE = 1'b1; ALU_S = 40'h44;
    cyc(1);
    ALU_DONE = 1'b0;
    check("rst_wait_valid", VALID, 40'h0);
    check("rst_wait_result", RESULT, 40'h0);
    check("rst_wait_busy", BUSY, 40'h0);

    // Watchdog or indefinite WAIT, then CLR
    issue(3'b000, 40'h1, 40'h1);
    cyc(2);
`ifdef CALC_SEQ_TIMEOUT_EN
    cyc(7);
    check("wd_not_yet", {38'h0, BUSY, ERR}, 40'h2);
    cyc(1);
    check("wd_err", ERR, 40'h1);
    check("wd_busy", BUSY, 40'h0);
    issue(3'b000, 40'h1, 40'h1);
    cyc(2);
    cyc(7);
    ALU_DONE = 1'b1; ALU_S = 40'h3;
    cyc(1);
    ALU_DONE = 1'b0;
    check("wd_done_wins_valid", VALID, 40'h1);
    check("wd_done_wins_err", ERR, 40'h0);
`else
    cyc(20);
    check("nowd_busy", BUSY, 40'h1);
    check("nowd_err", ERR, 40'h0);
`endif
    CLR = 1'b1;
    cyc(1);
    CLR = 1'b0;
    check("clr_busy", BUSY, 40'h0);
    check("clr_flags", {37'h0, VALID, ERR, OVF}, 40'h0);
    check("clr_opa", OPA, 40'h0);
    check("clr_result", RESULT, 40'h0);

    // CLR beats REQ in the same cycle
    A = 40'h33; OP = 3'b000; REQ = 1'b1; CLR = 1'b1;
    cyc(1);
    REQ = 1'b0; CLR = 1'b0;
    check("clr_beats_req_busy", BUSY, 40'h0);
    check("clr_beats_req_opa", OPA, 40'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
